// File: rtl/shift_arbiter.sv
`timescale 1ns/1ps
// shift_arbiter: shares one combinational barrel shifter between two requesters
// (operand-2 path and register-specified-shift unit). One operation is in flight at
// a time: IDLE accepts and latches the operands, EXEC drives the shifter and captures
// its result, RESP holds the result until the granted requester consumes it.
module shift_arbiter #(
  parameter int WIDTH      = 32,
  parameter int SHAMT_W    = 5,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*WIDTH-1:0]     req_a,
  input  logic [2*SHAMT_W-1:0]   req_shamt,
  input  logic [3:0]             req_type,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [WIDTH-1:0]       sh_a,
  output logic [SHAMT_W-1:0]     sh_shamt,
  output logic [1:0]             sh_type,
  input  logic [WIDTH-1:0]       sh_result,
  output logic                   busy,
  output logic [15:0]            grant_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       rr_ptr;
  logic       gnt_p0;   // winner chosen combinationally in IDLE
  logic       gnt_p1;   // winner of the operation currently in flight
  logic       accept;

  // Pick the winner: a lone requester wins outright, a tie goes to rr_ptr
  // (or always to requester 0 in fixed-priority mode).
  always_comb begin
    gnt_p0 = 1'b0;
    case (req_valid)
      2'b10:   gnt_p0 = 1'b1;
      2'b11:   gnt_p0 = FIXED_PRIO ? 1'b0 : rr_ptr;
      default: gnt_p0 = 1'b0;
    endcase
  end

  // Handshake outputs; req_ready is masked while reset is held low so no
  // requester sees an accept that the flops will not take.
  always_comb begin
    accept    = reset && (state == IDLE) && (req_valid != 2'b00);
    req_ready = 2'b00;
    if (accept) req_ready = gnt_p0 ? 2'b10 : 2'b01;
    rsp_valid = 2'b00;
    if (state == RESP) rsp_valid = gnt_p1 ? 2'b10 : 2'b01;
    busy      = (state != IDLE);
  end

  // Control FSM plus operand/result registers; sh_* only change on an accept
  // so the shifter inputs stay stable through EXEC and afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      gnt_p1    <= 1'b0;
      grant_cnt <= 16'd0;
      sh_a      <= '0;
      sh_shamt  <= '0;
      sh_type   <= 2'b00;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            gnt_p1    <= gnt_p0;
            sh_a      <= gnt_p0 ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
            sh_shamt  <= gnt_p0 ? req_shamt[2*SHAMT_W-1:SHAMT_W] : req_shamt[SHAMT_W-1:0];
            sh_type   <= gnt_p0 ? req_type[3:2] : req_type[1:0];
            grant_cnt <= grant_cnt + 16'd1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          rsp_data <= sh_result;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready[gnt_p1]) begin
            if (!FIXED_PRIO) rr_ptr <= ~gnt_p1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
`timescale 1ns/1ps
// Bench for shift_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model. A behavioural shifter stub closes the loop.
module tb_shift_arbiter;
  localparam int W  = 32;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // round-robin instance
  logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*W-1:0]  req_a;
  logic [2*SW-1:0] req_shamt;
  logic [3:0]      req_type;
  logic [W-1:0]    rsp_data, sh_a, sh_result;
  logic [SW-1:0]   sh_shamt;
  logic [1:0]      sh_type;
  logic            busy;
  logic [15:0]     grant_cnt;

  // fixed-priority instance
  logic [1:0]      f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready;
  logic [2*W-1:0]  f_req_a;
  logic [2*SW-1:0] f_req_shamt;
  logic [3:0]      f_req_type;
  logic [W-1:0]    f_rsp_data, f_sh_a, f_sh_result;
  logic [SW-1:0]   f_sh_shamt;
  logic [1:0]      f_sh_type;
  logic            f_busy;
  logic [15:0]     f_grant_cnt;

  int vectors = 0;
  int miscompares = 0;

  // bit-by-bit shifter stub standing in for the real barrel shifter
  function automatic logic [W-1:0] stub_shift(input logic [W-1:0] a, input logic [SW-1:0] s,
                                              input logic [1:0] t);
    logic [W-1:0] r;
    int j;
    r = '0;
    for (int i = 0; i < W; i++) begin
      case (t)
        2'b00: begin j = i - int'(s); if (j >= 0) r[i] = a[j]; end
        2'b01: begin j = i + int'(s); if (j < W) r[i] = a[j]; end
        2'b10: begin j = i + int'(s); r[i] = (j < W) ? a[j] : a[W-1]; end
        default: begin j = (i + int'(s)) % W; r[i] = a[j]; end
      endcase
    end
    return r;
  endfunction

  // reference result from plain arithmetic operators
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input logic [SW-1:0] s,
                                             input logic [1:0] t);
    logic [2*W-1:0] dbl;
    logic [W-1:0]   r;
    case (t)
      2'b00: r = a << s;
      2'b01: r = a >> s;
      2'b10: r = $signed(a) >>> s;
      default: begin dbl = {a, a} >> s; r = dbl[W-1:0]; end
    endcase
    return r;
  endfunction

  assign sh_result   = stub_shift(sh_a, sh_shamt, sh_type);
  assign f_sh_result = stub_shift(f_sh_a, f_sh_shamt, f_sh_type);

  shift_arbiter #(.WIDTH(W), .SHAMT_W(SW), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_shamt(req_shamt), .req_type(req_type),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .sh_a(sh_a), .sh_shamt(sh_shamt), .sh_type(sh_type), .sh_result(sh_result),
    .busy(busy), .grant_cnt(grant_cnt));

  shift_arbiter #(.WIDTH(W), .SHAMT_W(SW), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset), .req_valid(f_req_valid), .req_ready(f_req_ready),
    .req_a(f_req_a), .req_shamt(f_req_shamt), .req_type(f_req_type),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data),
    .sh_a(f_sh_a), .sh_shamt(f_sh_shamt), .sh_type(f_sh_type), .sh_result(f_sh_result),
    .busy(f_busy), .grant_cnt(f_grant_cnt));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00; req_a = '0; req_shamt = '0; req_type = '0;
    f_req_valid = 2'b00; f_rsp_ready = 2'b00; f_req_a = '0; f_req_shamt = '0; f_req_type = '0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [SW-1:0] s,
                         input logic [1:0] t);
    if (i == 0) begin
      req_a[W-1:0] = a; req_shamt[SW-1:0] = s; req_type[1:0] = t;
    end else begin
      req_a[2*W-1:W] = a; req_shamt[2*SW-1:SW] = s; req_type[3:2] = t;
    end
    req_valid[i] = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_req(0, 32'h0000_00F0, 5'd4, 2'b01);
    set_req(1, 32'h0000_0F00, 5'd4, 2'b00);
    rsp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      cyc();
      vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    end
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    vectors++; if (grant_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_grant_cnt: got %0d want 0", grant_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (rsp_data !== 32'd0 || sh_a !== 32'd0 || sh_shamt !== 5'd0 || sh_type !== 2'd0) begin
      miscompares++; $display("FAIL reset_data: rsp_data=%h sh_a=%h sh_shamt=%0d sh_type=%0d want all 0", rsp_data, sh_a, sh_shamt, sh_type);
    end
    reset = 1'b1;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL reset_first_grant: got %b want 01", req_ready); end
    cyc();
    req_valid = 2'b00;
    vectors++; if (grant_cnt !== 16'd1 || sh_a !== 32'h0000_00F0) begin
      miscompares++; $display("FAIL reset_first_op: grant_cnt=%0d sh_a=%h want 1 / 000000f0", grant_cnt, sh_a);
    end
  endtask

  task automatic test_single_op();
    logic [1:0]   typ [2] = '{2'b10, 2'b01};
    logic [W-1:0] exp [2] = '{32'hF800_0000, 32'h0800_0000};
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_req(0, 32'h8000_0000, 5'd4, typ[k]);
      rsp_ready = 2'b00;
      #1;
      vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL single_ready[%0d]: got %b want 01", k, req_ready); end
      cyc();
      req_valid = 2'b00;
      #1;
      vectors++; if (busy !== 1'b1 || rsp_valid !== 2'b00) begin miscompares++; $display("FAIL single_exec[%0d]: busy=%b rsp_valid=%b want 1/00", k, busy, rsp_valid); end
      vectors++; if (sh_a !== 32'h8000_0000 || sh_shamt !== 5'd4 || sh_type !== typ[k]) begin
        miscompares++; $display("FAIL single_sh[%0d]: sh_a=%h shamt=%0d type=%0d", k, sh_a, sh_shamt, sh_type);
      end
      cyc();
      vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL single_rsp_valid[%0d]: got %b want 01", k, rsp_valid); end
      vectors++; if (rsp_data !== exp[k]) begin miscompares++; $display("FAIL single_rsp_data[%0d]: got %h want %h", k, rsp_data, exp[k]); end
      rsp_ready = 2'b01;
      cyc();
      vectors++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin miscompares++; $display("FAIL single_done[%0d]: rsp_valid=%b busy=%b want 00/0", k, rsp_valid, busy); end
    end
  endtask

  task automatic test_contention();
    logic [W-1:0] exp [2] = '{32'h000F_00F0, 32'hFFF0_0000};
    do_reset();
    set_req(0, 32'h0000_F00F, 5'd4, 2'b00);
    set_req(1, 32'hF000_0000, 5'd8, 2'b10);
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (req_ready !== ((k % 2) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL contend_grant[%0d]: got %b want %b", k, req_ready, (k % 2) ? 2'b10 : 2'b01); end
      cyc();
      vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL contend_exec_ready[%0d]: got %b want 00", k, req_ready); end
      cyc();
      vectors++; if (rsp_valid !== ((k % 2) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL contend_rsp_valid[%0d]: got %b", k, rsp_valid); end
      vectors++; if (rsp_data !== exp[k % 2]) begin miscompares++; $display("FAIL contend_rsp_data[%0d]: got %h want %h", k, rsp_data, exp[k % 2]); end
      cyc();
    end
    vectors++; if (grant_cnt !== 16'd4) begin miscompares++; $display("FAIL contend_grant_cnt: got %0d want 4", grant_cnt); end
    req_valid = 2'b00;
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_req(1, 32'h0000_0001, 5'd1, 2'b11);
    #1;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL bp_grant_r1: got %b want 10", req_ready); end
    cyc();
    req_valid = 2'b00;
    set_req(0, 32'h0000_0010, 5'd1, 2'b01);
    cyc();
    rsp_ready = 2'b01;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++; if (rsp_valid !== 2'b10 || rsp_data !== 32'h8000_0000) begin
        miscompares++; $display("FAIL bp_hold[%0d]: rsp_valid=%b rsp_data=%h want 10/80000000", k, rsp_valid, rsp_data);
      end
      vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_r0_blocked[%0d]: got %b want 00", k, req_ready); end
      cyc();
    end
    rsp_ready = 2'b10;
    cyc();
    rsp_ready = 2'b11;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL bp_r0_after: got %b want 01", req_ready); end
    cyc();
    req_valid = 2'b00;
    cyc();
    vectors++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h0000_0008) begin
      miscompares++; $display("FAIL bp_r0_result: rsp_valid=%b rsp_data=%h want 01/00000008", rsp_valid, rsp_data);
    end
    cyc();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    set_req(0, 32'h1234_5678, 5'd8, 2'b11);
    rsp_ready = 2'b00;
    cyc();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    reset = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00 || grant_cnt !== 16'd0) begin
      miscompares++; $display("FAIL midrst_async: busy=%b rsp_valid=%b req_ready=%b grant_cnt=%0d want 0/00/00/0", busy, rsp_valid, req_ready, grant_cnt);
    end
    vectors++; if (sh_a !== 32'd0 || rsp_data !== 32'd0) begin miscompares++; $display("FAIL midrst_data: sh_a=%h rsp_data=%h want 0", sh_a, rsp_data); end
    cyc();
    req_valid = 2'b00;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      vectors++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin miscompares++; $display("FAIL midrst_stale[%0d]: rsp_valid=%b busy=%b want 00/0", k, rsp_valid, busy); end
    end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    f_req_a = {32'h0000_0003, 32'h0000_0001};
    f_req_shamt = {5'd1, 5'd31};
    f_req_type = {2'b00, 2'b11};
    f_req_valid = 2'b11;
    f_rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (f_req_ready !== 2'b01) begin miscompares++; $display("FAIL fp_grant[%0d]: got %b want 01", k, f_req_ready); end
      cyc();
      cyc();
      vectors++; if (f_rsp_valid !== 2'b01 || f_rsp_data !== 32'h0000_0002) begin
        miscompares++; $display("FAIL fp_rsp[%0d]: rsp_valid=%b rsp_data=%h want 01/00000002", k, f_rsp_valid, f_rsp_data);
      end
      cyc();
    end
    vectors++; if (f_grant_cnt !== 16'd4) begin miscompares++; $display("FAIL fp_grant_cnt: got %0d want 4", f_grant_cnt); end
    f_req_valid = 2'b00;
  endtask

  // Transaction-level model: one op in flight, result visible two cycles after
  // the accept cycle, round-robin pointer moves to the other requester on consume.
  task automatic test_random(input int n);
    logic         act, g, g_new, rr, shown;
    int           t_acc, cyc_no;
    logic [1:0]   hold, exp_rdy, exp_rv;
    logic [15:0]  exp_cnt;
    logic [W-1:0] ra [2];
    logic [SW-1:0] rs [2];
    logic [1:0]   rt [2];
    logic [W-1:0] op_a;
    logic [SW-1:0] op_s;
    logic [1:0]   op_t;
    do_reset();
    act = 1'b0; g = 1'b0; rr = 1'b0; exp_cnt = 16'd0; cyc_no = 0; t_acc = 0; hold = 2'b00;
    op_a = '0; op_s = '0; op_t = '0;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!hold[i] && $urandom_range(0, 1) == 1) begin
          ra[i] = $urandom;
          rs[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          rt[i] = 2'($urandom_range(0, 3));
          set_req(i, ra[i], rs[i], rt[i]);
          hold[i] = 1'b1;
        end
      end
      req_valid = hold;
      rsp_ready = 2'($urandom_range(0, 3));
      #1;
      shown = act && (cyc_no >= t_acc + 2);
      exp_rdy = 2'b00;
      g_new = 1'b0;
      if (!act && hold != 2'b00) begin
        g_new = (hold == 2'b11) ? rr : hold[1];
        exp_rdy = g_new ? 2'b10 : 2'b01;
      end
      exp_rv = shown ? (g ? 2'b10 : 2'b01) : 2'b00;
      vectors++; if (req_ready !== exp_rdy) begin miscompares++; $display("FAIL rnd_req_ready cyc=%0d: got %b want %b", c, req_ready, exp_rdy); end
      vectors++; if (rsp_valid !== exp_rv) begin miscompares++; $display("FAIL rnd_rsp_valid cyc=%0d: got %b want %b", c, rsp_valid, exp_rv); end
      vectors++; if (busy !== act || grant_cnt !== exp_cnt) begin
        miscompares++; $display("FAIL rnd_busy_cnt cyc=%0d: busy=%b cnt=%0d want %b/%0d", c, busy, grant_cnt, act, exp_cnt);
      end
      if (shown) begin
        vectors++; if (rsp_data !== ref_shift(op_a, op_s, op_t)) begin
          miscompares++; $display("FAIL rnd_rsp_data cyc=%0d: got %h want %h", c, rsp_data, ref_shift(op_a, op_s, op_t));
        end
      end
      if (act) begin
        vectors++; if (sh_a !== op_a || sh_shamt !== op_s || sh_type !== op_t) begin
          miscompares++; $display("FAIL rnd_sh cyc=%0d: %h/%0d/%0d want %h/%0d/%0d", c, sh_a, sh_shamt, sh_type, op_a, op_s, op_t);
        end
      end
      @(posedge clk);
      if (exp_rdy != 2'b00) begin
        act = 1'b1; t_acc = cyc_no; g = g_new;
        op_a = ra[g_new]; op_s = rs[g_new]; op_t = rt[g_new];
        hold[g_new] = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
      end else if (shown && rsp_ready[g]) begin
        act = 1'b0;
        rr = ~g;
      end
      cyc_no++;
      #1;
    end
    req_valid = 2'b00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    test_reset();
    test_single_op();
    test_contention();
    test_back_pressure();
    test_reset_mid_op();
    test_fixed_prio();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
